// File: rtl/tc3_gf2_pkg.sv
// Shared constants, limb offsets and FSM encoding for the 3-way split GF(2) multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tc3_gf2_pkg;

  // Operand width, per-limb step count and product width.
  localparam int N     = 233;
  localparam int K     = 78;
  localparam int CW    = 2 * N;
  localparam int NPROD = 9;

  // Counter widths: phase index 0..8, bit index 0..K-1.
  localparam int PW = 4;
  localparam int KW = 7;

  // Shift amounts are at most OFF2 + OFF2 + K - 1 = 387, so 9 bits suffice.
  localparam int SW = 9;

  // Bit position of each limb inside the 233-bit operand.
  localparam int OFF0 = 0;
  localparam int OFF1 = 78;
  localparam int OFF2 = 155;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit offset of limb idx; idx 3 never occurs and maps to the top limb.
  function automatic logic [SW-1:0] limb_off(input logic [1:0] idx);
    logic [SW-1:0] off;
    case (idx)
      2'd0:    off = SW'(OFF0);
      2'd1:    off = SW'(OFF1);
      default: off = SW'(OFF2);
    endcase
    return off;
  endfunction

  // Extract limb idx as a K-bit value. The middle limb is only 77 bits
  // wide (bits 154:78), so its MSB is forced to zero.
  function automatic logic [K-1:0] limb_sel(input logic [N-1:0] x, input logic [1:0] idx);
    logic [K-1:0] l;
    case (idx)
      2'd0:    l = x[OFF1-1:OFF0];
      2'd1:    l = {1'b0, x[OFF2-1:OFF1]};
      default: l = x[N-1:OFF2];
    endcase
    return l;
  endfunction

endpackage

// File: rtl/gf2_serial_mac_step.sv
// One bit-serial shift-and-XOR step of a limb sub-product ai*bj into the accumulator.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is registered.
//
// Ports:
//   acc_i : current accumulator (CW bits)
//   a_i   : latched multiplicand, b_i : latched multiplier (N bits each)
//   p_i   : sub-product index 0..8, i = p/3 selects the a limb, j = p%3 the b limb
//   k_i   : bit index inside the a limb, 0..K-1
//   acc_o : accumulator after conditionally XORing bj << (OFF[i]+OFF[j]+k)
module gf2_serial_mac_step
  import tc3_gf2_pkg::*;
(
  input  logic [CW-1:0] acc_i,
  input  logic [N-1:0]  a_i,
  input  logic [N-1:0]  b_i,
  input  logic [PW-1:0] p_i,
  input  logic [KW-1:0] k_i,
  output logic [CW-1:0] acc_o
);

  logic [1:0]    i_sel;
  logic [1:0]    j_sel;
  logic [K-1:0]  a_limb;
  logic [K-1:0]  b_limb;
  logic          a_bit;
  logic [SW-1:0] shamt;
  logic [CW-1:0] term;

  // p -> (p/3, p%3) as a table; avoids a divider for a 4-bit index.
  always_comb begin
    i_sel = 2'd0;
    j_sel = 2'd0;
    case (p_i)
      4'd0: begin i_sel = 2'd0; j_sel = 2'd0; end
      4'd1: begin i_sel = 2'd0; j_sel = 2'd1; end
      4'd2: begin i_sel = 2'd0; j_sel = 2'd2; end
      4'd3: begin i_sel = 2'd1; j_sel = 2'd0; end
      4'd4: begin i_sel = 2'd1; j_sel = 2'd1; end
      4'd5: begin i_sel = 2'd1; j_sel = 2'd2; end
      4'd6: begin i_sel = 2'd2; j_sel = 2'd0; end
      4'd7: begin i_sel = 2'd2; j_sel = 2'd1; end
      4'd8: begin i_sel = 2'd2; j_sel = 2'd2; end
      default: begin i_sel = 2'd0; j_sel = 2'd0; end
    endcase
  end

  always_comb begin
    a_limb = limb_sel(a_i, i_sel);
    b_limb = limb_sel(b_i, j_sel);
    a_bit  = a_limb[k_i];
    shamt  = limb_off(i_sel) + limb_off(j_sel) + SW'(k_i);
    // Highest set bit reachable is 387 + 77 = 464, so nothing is shifted out.
    term   = {{(CW-K){1'b0}}, b_limb} << shamt;
    acc_o  = a_bit ? (acc_i ^ term) : acc_i;
  end

endmodule

// File: rtl/tc3_gf2_mul_sched.sv
// Scheduler sharing one bit-serial GF(2) MAC across all nine limb sub-products of a 233x233 carry-less multiply.
// Latency: accept at cycle T -> out_valid at T+703 (9*78 MUL cycles, fixed, no zero skipping).
// Backpressure: in_ready only in IDLE; c/out_valid hold in DONE until out_ready; one product per >= 704 cycles.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake for a, b (N bits each)
//   out_valid/out_ready : result handshake for c (CW bits, bit 465 always 0)
//   busy              : high in MUL and DONE
//   phase             : sub-product index being processed, 0 outside MUL
module tc3_gf2_mul_sched
  import tc3_gf2_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] c,
  output logic          busy,
  output logic [PW-1:0] phase
);

  state_t        state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] c_q, c_d;
  logic [CW-1:0] acc_step;

  gf2_serial_mac_step u_mac (
    .acc_i (acc_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .p_i   (p_q),
    .k_i   (k_q),
    .acc_o (acc_step)
  );

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    c_d       = c_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    phase     = '0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          p_d     = '0;
          k_d     = '0;
          state_d = MUL;
        end
      end

      MUL: begin
        phase = p_q;
        acc_d = acc_step;
        if (k_q == KW'(K-1)) begin
          k_d = '0;
          if (p_q == PW'(NPROD-1)) begin
            // The final step's contribution is folded in here, so c is the
            // complete product the moment out_valid rises.
            p_d     = '0;
            c_d     = acc_step;
            state_d = DONE;
          end else begin
            p_d = p_q + PW'(1);
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign c = c_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
    end
  end

endmodule
